// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//   Main control FSM of the multi-cycle MIPS CPU. Steps each instruction
//   through fetch / decode / execute / memory / writeback over a shared ALU,
//   one memory port and the register file. It drives the datapath mux
//   selects, the write enables and a 2-bit ALUOp for the ALU control decoder.
//   It also counts retired instructions.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   OpCode       IR[31:26]
//   Funct        IR[5:0]
//   mem_ready    memory completes the current access this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load when ALU Zero is set
//   IorD         memory address select: 0 PC, 1 ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      load IR and MDR
//   MemtoReg     RF write data: 0 ALUOut, 1 MDR, 2 PC
//   RegDst       RF write address: 0 rt, 1 rd, 2 $31
//   RegWrite     register file write
//   ALUSrcA      0 PC, 1 reg A, 2 shamt
//   ALUSrcB      0 reg B, 1 const 4, 2 ext imm, 3 ext imm<<2
//   ALUOp        00 add, 01 sub, 10 decode OpCode/Funct
//   PCSource     0 ALU result, 1 ALUOut, 2 jump target, 3 reg A
//   ExtOp        1 sign-extend imm, 0 zero-extend
//   LuiOp        select the imm<<16 path
//   illegal      one-cycle pulse in DECODE on an unsupported instruction
//   state        current FSM state (debug)
//   instr_count  retired instruction count, wraps
//
// Memory handshake: MemRead or MemWrite is a request that stays asserted
// while the FSM waits in FETCH, MEM_READ or MEM_WRITE. The access completes
// on the first rising edge where mem_ready is 1 together with the request.
// The FSM advances only on that edge. mem_ready is ignored in all other
// states.
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             LuiOp,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_EXEC_I    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_JUMP_REG  = 4'd12;

    logic [3:0] cur_state;
    logic [3:0] nxt_state;

    // Instruction classification from the IR fields.
    logic is_mem;
    logic is_jr;
    logic is_r;
    logic is_shift;
    logic is_i;
    logic retire;

    always_comb begin
        is_mem   = (OpCode == 6'h23) || (OpCode == 6'h2b);
        is_jr    = (OpCode == 6'h00) && ((Funct == 6'h08) || (Funct == 6'h09));
        is_shift = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);
        is_r     = (OpCode == 6'h00) &&
                   (((Funct >= 6'h20) && (Funct <= 6'h27)) ||
                    (Funct == 6'h2a) || (Funct == 6'h2b) || is_shift);
        is_i     = (OpCode == 6'h08) || (OpCode == 6'h09) || (OpCode == 6'h0a) ||
                   (OpCode == 6'h0b) || (OpCode == 6'h0c) || (OpCode == 6'h0f);
    end

    // An instruction retires when any state other than DECODE or FETCH
    // returns to FETCH. An illegal instruction leaves DECODE and is not
    // counted. Unused codes 13-15 are not instructions, so they are not
    // counted either.
    always_comb begin
        retire = 1'b0;
        case (cur_state)
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH,
            S_JUMP, S_I_WB, S_JUMP_REG: retire = (nxt_state == S_FETCH);
            default:                    retire = 1'b0;
        endcase
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state   <= S_FETCH;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire)
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:     nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem)                   nxt_state = S_MEM_ADDR;
                else if (is_jr)               nxt_state = S_JUMP_REG;
                else if (is_r)                nxt_state = S_EXEC_R;
                else if (OpCode == 6'h04)     nxt_state = S_BRANCH;
                else if ((OpCode == 6'h02) ||
                         (OpCode == 6'h03))   nxt_state = S_JUMP;
                else if (is_i)                nxt_state = S_EXEC_I;
                else                          nxt_state = S_FETCH;
            end
            S_MEM_ADDR:  nxt_state = (OpCode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    nxt_state = S_R_WB;
            S_EXEC_I:    nxt_state = S_I_WB;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Output decode. State-changing enables are gated with reset so that
    // nothing is written while reset is held. This holds even though the
    // state register already shows FETCH during reset.
    logic pc_write;
    logic pc_write_cond;
    logic ir_write;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic illegal_i;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        illegal_i     = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 2'd0;
        RegDst        = 2'd0;
        ALUSrcA       = 2'd0;
        ALUSrcB       = 2'd0;
        ALUOp         = 2'b00;
        PCSource      = 2'd0;
        ExtOp         = 1'b0;
        LuiOp         = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'd1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB   = 2'd3;
                ExtOp     = 1'b1;
                illegal_i = !(is_mem || is_jr || is_r || is_i || (OpCode == 6'h04) ||
                              (OpCode == 6'h02) || (OpCode == 6'h03));
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ExtOp   = 1'b1;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                MemtoReg  = 2'd1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = is_shift ? 2'd2 : 2'd1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                RegDst    = 2'd1;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp   = 2'b10;
                ExtOp   = (OpCode != 6'h0c) && (OpCode != 6'h0f);
                LuiOp   = (OpCode == 6'h0f);
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 2'd1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                PCSource      = 2'd1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'd2;
                if (OpCode == 6'h03) begin
                    reg_write = 1'b1;
                    RegDst    = 2'd2;
                    MemtoReg  = 2'd2;
                end
            end
            S_JUMP_REG: begin
                pc_write = 1'b1;
                PCSource = 2'd3;
                if (Funct == 6'h09) begin
                    reg_write = 1'b1;
                    RegDst    = 2'd1;
                    MemtoReg  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign PCWrite     = pc_write      & reset;
    assign PCWriteCond = pc_write_cond & reset;
    assign IRWrite     = ir_write      & reset;
    assign RegWrite    = reg_write     & reset;
    assign MemRead     = mem_read      & reset;
    assign MemWrite    = mem_write     & reset;
    assign illegal     = illegal_i     & reset;
    assign state       = cur_state;

endmodule
